pio_reg_bridge: RTL and testbench

//  Parametrised HPS-to-fabric register bridge driven by lightweight PIO exports (address/read/write/

---
 rtl/pio_reg_bridge_pkg.sv | 13 +
 rtl/pio_sync_edge.sv | 29 ++
 rtl/pio_reg_bridge.sv | 157 +++++++++++++++
 tb/tb_pio_reg_bridge.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pio_reg_bridge_pkg.sv
// Shared types and constants for the PIO register bridge.
package pio_reg_bridge_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_ACK} state_e;

  localparam int unsigned ERR_CNT_W = 8;

  // Highest address in the register space is the status/error register.
  function automatic int unsigned status_addr(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Synchroniser plus rising-edge detector for one asynchronous request level.
module pio_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Chain and history reset high so a level held across reset release is not an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pio_reg_bridge.sv
// HPS PIO to fabric register bridge: four-phase ack, coherent read snapshot, write channels, error count.
module pio_reg_bridge
  import pio_reg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_RD        = 6,
  parameter int unsigned N_WR        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pio_address,
  input  logic                     pio_read,
  input  logic                     pio_write,
  input  logic [DATA_W-1:0]        pio_writedata,
  output logic [DATA_W-1:0]        pio_readdata,
  output logic                     pio_ack,
  input  logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_WR*DATA_W-1:0]   wr_data,
  output logic [N_WR-1:0]          wr_strobe,
  output logic                     snap_strobe
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(ADDR_W));
  localparam logic [ADDR_W:0]   N_RD_L      = (ADDR_W+1)'(N_RD);
  localparam logic [ADDR_W:0]   N_WR_L      = (ADDR_W+1)'(N_WR);

  logic rd_level, rd_rise, wr_level, wr_rise;

  pio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk_i  (clk),
    .reset_i(reset),
    .async_i(pio_read),
    .level_o(rd_level),
    .rise_o (rd_rise)
  );

  pio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk_i  (clk),
    .reset_i(reset),
    .async_i(pio_write),
    .level_o(wr_level),
    .rise_o (wr_rise)
  );

  state_e                 state_q;
  logic                   op_wr_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   ack_q;
  logic                   snap_q;
  logic [N_WR-1:0]        wr_strobe_q;
  logic [DATA_W-1:0]      wr_data_q [N_WR];
  logic [DATA_W-1:0]      shadow_q  [N_RD];
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic              rd_ok, wr_ok, rd_status, act_level;
  logic              edge_err, acc_err, err_inc, err_clr;
  logic [DATA_W-1:0] rd_sel_d;

  assign rd_ok     = {1'b0, addr_q} < N_RD_L;
  assign wr_ok     = {1'b0, addr_q} < N_WR_L;
  assign rd_status = addr_q == STATUS_ADDR;
  assign act_level = op_wr_q ? wr_level : rd_level;

  always_comb begin
    rd_sel_d = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      if (addr_q == ADDR_W'(i)) rd_sel_d = shadow_q[i];
    end
  end

  // A status read clears the counter, but an error in that same cycle still counts as one.
  always_comb begin
    edge_err  = (state_q == ST_IDLE) ? (rd_rise & wr_rise) : (rd_rise | wr_rise);
    acc_err   = (state_q == ST_EXEC) && (op_wr_q ? !wr_ok : !(rd_ok || rd_status));
    err_inc   = edge_err | acc_err;
    err_clr   = (state_q == ST_EXEC) && !op_wr_q && rd_status;
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = ERR_CNT_W'(err_inc);
    else if (err_inc && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      snap_q      <= 1'b0;
      wr_strobe_q <= '0;
      err_cnt_q   <= '0;
      for (int unsigned i = 0; i < N_WR; i++) wr_data_q[i] <= '0;
      for (int unsigned i = 0; i < N_RD; i++) shadow_q[i] <= '0;
    end else begin
      wr_strobe_q <= '0;
      snap_q      <= 1'b0;
      err_cnt_q   <= err_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (rd_rise ^ wr_rise) begin
            op_wr_q <= wr_rise;
            addr_q  <= pio_address;
            wdata_q <= pio_writedata;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_ACK;
          ack_q   <= 1'b1;
          if (op_wr_q) begin
            for (int unsigned i = 0; i < N_WR; i++) begin
              if (wr_ok && ({1'b0, addr_q} == (ADDR_W+1)'(i))) begin
                wr_data_q[i]   <= wdata_q;
                wr_strobe_q[i] <= 1'b1;
              end
            end
          end else if (addr_q == '0) begin
            for (int unsigned i = 0; i < N_RD; i++)
              shadow_q[i] <= rd_data[i*DATA_W +: DATA_W];
            rdata_q <= rd_data[DATA_W-1:0];
            snap_q  <= 1'b1;
          end else if (rd_ok) begin
            rdata_q <= rd_sel_d;
          end else if (rd_status) begin
            rdata_q <= DATA_W'(err_cnt_q);
          end else begin
            rdata_q <= '0;
          end
        end
        ST_ACK: begin
          if (!act_level) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_WR; g++) begin : g_wr_out
    assign wr_data[g*DATA_W +: DATA_W] = wr_data_q[g];
  end

  assign pio_readdata = rdata_q;
  assign pio_ack      = ack_q;
  assign wr_strobe    = wr_strobe_q;
  assign snap_strobe  = snap_q;

endmodule

// File: tb/tb_pio_reg_bridge.sv
// Scoreboard bench for pio_reg_bridge: driver queues expected responses, monitor checks at each ack rise.
module tb_pio_reg_bridge;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_RD   = 6;
  localparam int unsigned N_WR   = 2;
  localparam int unsigned SYNC   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [ADDR_W-1:0]      pio_address;
  logic                   pio_read, pio_write;
  logic [DATA_W-1:0]      pio_writedata;
  logic [DATA_W-1:0]      pio_readdata;
  logic                   pio_ack;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_WR*DATA_W-1:0] wr_data;
  logic [N_WR-1:0]        wr_strobe;
  logic                   snap_strobe;

  pio_reg_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD), .N_WR(N_WR), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .pio_address(pio_address), .pio_read(pio_read),
    .pio_write(pio_write), .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
    .pio_ack(pio_ack), .rd_data(rd_data), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .snap_strobe(snap_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [1:0]  wstb;
    bit          snap;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   failed   = 0;
  int   stray    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every ack rise completes exactly one queued access.
  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_prev = 1'b0;
      end else if (pio_ack && !ack_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_strobe", 64'(wr_strobe), 64'(e.wstb));
          chk("snap_strobe", 64'(snap_strobe), 64'(e.snap));
          if (e.is_rd) chk("readdata", 64'(pio_readdata), 64'(e.data));
        end
      end else if (wr_strobe != '0 || snap_strobe) begin
        stray++;
      end
      if (!reset) ack_prev = pio_ack;
    end
  end

  task automatic start(input bit wr, input logic [2:0] a, input logic [31:0] d, input exp_t e);
    @(negedge clk);
    pio_address   = a;
    pio_writedata = d;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    if (wr) pio_write = 1'b1;
    else    pio_read  = 1'b1;
  endtask

  task automatic wait_ack(input logic lvl, input int req_n, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pio_ack !== lvl && n < 30);
    chk(nm, 64'(n), 64'(req_n));
  endtask

  task automatic access(input bit wr, input logic [2:0] a, input logic [31:0] d, input exp_t e);
    start(wr, a, d, e);
    wait_ack(1'b1, SYNC + 2, "ack_rise_latency");
    #1;
    if (wr) pio_write = 1'b0;
    else    pio_read  = 1'b0;
    wait_ack(1'b0, SYNC + 1, "ack_fall_latency");
  endtask

  function automatic exp_t rd_exp(input logic [31:0] d, input bit s);
    exp_t e;
    e.is_rd = 1'b1; e.data = d; e.wstb = 2'b00; e.snap = s;
    return e;
  endfunction

  function automatic exp_t wr_exp(input logic [1:0] stb);
    exp_t e;
    e.is_rd = 1'b0; e.data = '0; e.wstb = stb; e.snap = 1'b0;
    return e;
  endfunction

  initial begin
    reset = 1'b1; pio_address = '0; pio_read = 1'b0; pio_write = 1'b1;
    pio_writedata = '0; rd_data = '0;

    // 1: write level held through reset release gives no access
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ack", 64'(pio_ack), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_readdata", 64'(pio_readdata), 64'd0);
    pio_write = 1'b0;
    repeat (6) @(negedge clk);

    // 2: write channel 1
    access(1'b1, 3'd1, 32'h0000_1234, wr_exp(2'b10));
    chk("wr_ch1", 64'(wr_data[63:32]), 64'h1234);
    chk("wr_ch0", 64'(wr_data[31:0]), 64'h0);

    // 3: coherent snapshot
    rd_data[31:0] = 32'd10; rd_data[63:32] = 32'd20; rd_data[95:64] = 32'd30;
    access(1'b0, 3'd0, '0, rd_exp(32'd10, 1'b1));
    rd_data[31:0] = 32'd11; rd_data[63:32] = 32'd21; rd_data[95:64] = 32'd31;
    access(1'b0, 3'd1, '0, rd_exp(32'd20, 1'b0));
    access(1'b0, 3'd2, '0, rd_exp(32'd30, 1'b0));

    // 4: simultaneous edges -> no access, one error
    @(negedge clk);
    #1;
    pio_read = 1'b1; pio_write = 1'b1;
    repeat (8) @(negedge clk);
    chk("both_no_ack", 64'(pio_ack), 64'd0);
    pio_read = 1'b0; pio_write = 1'b0;
    repeat (5) @(negedge clk);
    access(1'b0, 3'd7, '0, rd_exp(32'd1, 1'b0));
    access(1'b0, 3'd7, '0, rd_exp(32'd0, 1'b0));

    // 5: out-of-range writes saturate the error count
    for (int i = 0; i < 300; i++) access(1'b1, 3'd5, 32'hFFFF_FFFF, wr_exp(2'b00));
    chk("bad_wr_data", 64'(wr_data), {32'h1234, 32'h0});
    access(1'b0, 3'd7, '0, rd_exp(32'd255, 1'b0));

    // 6: write edge during ack of a read is ignored
    start(1'b0, 3'd0, '0, rd_exp(32'd11, 1'b1));
    wait_ack(1'b1, SYNC + 2, "ack_rise_latency");
    #1;
    pio_address = 3'd0; pio_writedata = 32'hDEAD_BEEF; pio_write = 1'b1;
    repeat (6) @(negedge clk);
    chk("ack_held", 64'(pio_ack), 64'd1);
    #1;
    pio_read = 1'b0;
    wait_ack(1'b0, SYNC + 1, "ack_fall_latency");
    repeat (6) @(negedge clk);
    pio_write = 1'b0;
    repeat (5) @(negedge clk);
    chk("ignored_wr_data", 64'(wr_data), {32'h1234, 32'h0});
    access(1'b0, 3'd7, '0, rd_exp(32'd1, 1'b0));

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("stray_strobes", 64'(stray), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
